// File: rtl/cla_pkg.sv
// cla_pkg: group width, lookahead generate/propagate helper and stage flag record for cla_pipe_adder.
package cla_pkg;
    localparam int GROUP_W = 4;
    typedef struct packed {
        logic [GROUP_W-1:0] g;
        logic [GROUP_W-1:0] p;
    } gp_t;
    typedef struct packed {
        logic valid;
        logic carry;
    } stg_flags_t;
    function automatic gp_t cla_gp(input logic [GROUP_W-1:0] a, input logic [GROUP_W-1:0] b);
        return '{g: a & b, p: a ^ b};
    endfunction
endpackage

// File: rtl/cla_group.sv
// cla_group: combinational 4-bit carry-lookahead group producing sum bits and group carry-out.
module cla_group import cla_pkg::*; (
    input  logic [GROUP_W-1:0] i_a,
    input  logic [GROUP_W-1:0] i_b,
    input  logic               i_c,
    output logic [GROUP_W-1:0] o_s,
    output logic               o_c
);
    gp_t                w_gp;
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W:0]   w_c;
    assign w_gp = cla_gp(i_a, i_b);
    assign w_g = w_gp.g;
    assign w_p = w_gp.p;
    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);
    assign o_s = w_p ^ w_c[GROUP_W-1:0];
    assign o_c = w_c[GROUP_W];
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor, one 4-bit group resolved per stage.
module cla_pipe_adder import cla_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NSTG = WIDTH / GROUP;
    localparam logic [WIDTH-1:0] TOP_MASK = ~({WIDTH{1'b1}} >> GROUP);
    typedef struct packed {
        stg_flags_t       f;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_done;
    } stage_t;
    if (GROUP != GROUP_W || WIDTH < GROUP || WIDTH % GROUP != 0) begin : g_bad_cfg
        $error("cla_pipe_adder: GROUP must be 4 and WIDTH a positive multiple of GROUP");
    end
    stage_t           r_stg [NSTG];
    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             w_en;
    logic [WIDTH-1:0] w_sum;
    logic [NSTG-1:0]  w_co;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    assign w_en = !r_out_valid || out_ready;
    assign in_ready = w_en;
    assign out_valid = r_out_valid;
    assign s = r_s;
    assign cout = r_cout;
    assign ovf = r_ovf;
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        cla_group u_grp (
            .i_a (r_stg[k].a_rem[GROUP*k +: GROUP]),
            .i_b (r_stg[k].b_rem[GROUP*k +: GROUP]),
            .i_c (r_stg[k].f.carry),
            .o_s (w_sum[GROUP*k +: GROUP]),
            .o_c (w_co[k])
        );
    end
    assign w_res = r_stg[NSTG-1].sum_done | (w_sum & TOP_MASK);
    // a^b^s at the MSB recovers the carry into the MSB
    assign w_ovf = r_stg[NSTG-1].a_rem[WIDTH-1] ^ r_stg[NSTG-1].b_rem[WIDTH-1]
                 ^ w_sum[WIDTH-1] ^ w_co[NSTG-1];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) r_stg[i] <= '0;
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_en) begin
            r_stg[0] <= '{f: '{valid: in_valid, carry: sub | cin},
                          a_rem: a, b_rem: sub ? ~b : b, sum_done: '0};
            for (int i = 1; i < NSTG; i++) begin
                r_stg[i] <= r_stg[i-1];
                r_stg[i].f.carry <= w_co[i-1];
                r_stg[i].sum_done[GROUP*(i-1) +: GROUP] <= w_sum[GROUP*(i-1) +: GROUP];
            end
            r_out_valid <= r_stg[NSTG-1].f.valid;
            if (r_stg[NSTG-1].f.valid) begin
                r_s    <= w_res;
                r_cout <= w_co[NSTG-1];
                r_ovf  <= w_ovf;
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: scoreboard bench for cla_pipe_adder (WIDTH=16): directed, stall, reset and random traffic.
module tb_cla_pipe_adder;
    localparam int W = 16;
    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         rnd = 1'b0;
    logic         or_force = 1'b1;
    logic         or_rand = 1'b1;
    int           n_vec = 0;
    int           n_err = 0;
    exp_t         q[$];
    exp_t         e;
    logic [W-1:0] hold;

    cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;
    assign out_ready = rnd ? or_rand : or_force;
    always @(posedge clk) begin
        #1;
        or_rand = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        exp_t         m;
        logic [W:0]   u;
        longint       r;
        if (sb) begin
            u = {1'b0, x} - {1'b0, y};
            m.cout = (x >= y);
            r = longint'($signed(x)) - longint'($signed(y));
        end else begin
            u = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            m.cout = u[W];
            r = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        end
        m.s = u[W-1:0];
        m.ovf = (r > longint'(2**(W-1) - 1)) || (r < -longint'(2**(W-1)));
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("s", s, e.s);
                    chk("cout", cout, e.cout);
                    chk("ovf", ovf, e.ovf);
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic lat_check(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        send(x, y, ci, sb);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("latency_valid", out_valid, i == 5);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && q.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk);
        #1;
        lat_check(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0003, 16'h0005, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        send(16'h1234, 16'h0FFF, 1'b1, 1'b0);
        send(16'h0005, 16'h0005, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b0, 1'b1);
        drain();
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'h1111 * i[15:0], 16'h0F0F + i[15:0], i[0], i[1]);
            end
            begin
                repeat (6) @(posedge clk);
                #1 or_force = 1'b0;
                @(negedge clk);
                hold = s;
                for (int i = 0; i < 3; i++) begin
                    if (i != 0) @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_s_hold", s, hold);
                end
                @(posedge clk);
                #1 or_force = 1'b1;
            end
        join
        drain();
        for (int i = 0; i < 3; i++) send(16'hAAAA + i[15:0], 16'h5555, 1'b1, 1'b0);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_s", s, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_ovf", ovf, 0);
        repeat (6) @(posedge clk);
        #1;
        lat_check(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
        drain();
        rnd = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) @(posedge clk);
            #0;
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        rnd = 1'b0;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
